rf_wb_arbiter: RTL
==================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter RAW, default 4: register-file address width (2**RAW registers).
REQ-002 Parameter DW, default 8: write-data width.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 alu_valid_i  input  1  ALU writeback request.
REQ-006 alu_addr_i  input  RAW  ALU destination register.
REQ-007 alu_data_i  input  DW  ALU result.
REQ-008 alu_ready_o  output  1  ALU request accepted this cycle.
REQ-009 ld_valid_i  input  1  load writeback request.
REQ-010 ld_addr_i  input  RAW  load destination register.
REQ-011 ld_data_i  input  DW  load data.
REQ-012 ld_ready_o  output  1  load request accepted this cycle.
REQ-013 stall_i  input  1  controller hold; blocks all grants.
REQ-014 wen_o  output  1  write enable to the register file.
REQ-015 write_addr_o  output  RAW  register-file write pointer.
REQ-016 write_data_o  output  DW  register-file write data.
REQ-017 conflict_cnt_o  output  8  saturating count of cycles with both requests valid.

Function
REQ-018 A transfer occurs on a requester when valid_i and ready_o are both high at a posedge.
REQ-019 ready_o is combinational from valid inputs, stall_i and the arbitration pointer; at most one ready_o is high per cycle.
REQ-020 With stall_i high, both ready_o are low; the pointer and counter are unchanged.
REQ-021 With one request valid and stall_i low, that requester is granted.
REQ-022 With both valid, the requester not granted last is granted (round-robin); pointer last_gnt updates only on a transfer.
REQ-023 Output stage registered: the write granted in cycle N appears on wen_o/write_addr_o/write_data_o in cycle N+1 for exactly one cycle.
REQ-024 With no transfer in cycle N, wen_o is low in cycle N+1; write_addr_o and write_data_o hold their previous values.
REQ-025 Both requesters targeting the same address: writes occur in grant order; the later write wins in the register file.
REQ-026 An ungranted requester holds valid, address and data stable until granted; the block does not buffer requests.
REQ-027 conflict_cnt_o increments by 1 each cycle both valid_i are high and stall_i is low, and saturates at 255.

Reset
REQ-028 While rst_n is low: wen_o=0, write_addr_o=0, write_data_o=0, conflict_cnt_o=0, last_gnt=load (ALU wins the first conflict).
REQ-029 Reset asserted mid-transfer discards the pending output write; no wen_o pulse follows deassertion.
REQ-030 ready_o outputs are low whenever rst_n is low.

Configuration
REQ-031 Macro RF_WB_RR_EN defined: round-robin per REQ-022.
REQ-032 RF_WB_RR_EN undefined: fixed priority, load always wins over ALU; last_gnt is not implemented; all other behaviour is unchanged.

Structure
REQ-033 The shared package rf_pkg holds the RAW/DW defaults, typedef wb_req_t {valid, addr, data} and the enum gnt_e {GNT_ALU, GNT_LD}.
REQ-034 Sub-module rf_wb_rr_pick (2-way grant plus pointer) is instantiated once; the output register and counter stay in the top module.

Verification
REQ-035 ALU only: alu_valid=1, addr=3, data=0x5A -> alu_ready=1 same cycle; next cycle wen=1, addr=3, data=0x5A; following cycle wen=0.
REQ-036 Both valid for 4 cycles after reset (ALU addr=1/0x11, load addr=2/0x22, each dropping valid after its grant) -> ALU granted first, load second; wen pulses carry 0x11 and then 0x22; conflict_cnt=1.
REQ-037 Same address 5 from both requesters (ALU 0xAA, load 0xBB) -> two wen pulses in grant order; a register-file model reads 0xBB for register 5.
REQ-038 stall_i=1 for 3 cycles with both valid -> both ready=0, wen=0, conflict_cnt unchanged; stall released -> normal arbitration resumes.
REQ-039 Both valid held for 300 cycles -> conflict_cnt_o saturates at 255; with RF_WB_RR_EN undefined, ld_ready=1 every cycle.
REQ-040 rst_n pulled low the cycle after a grant -> wen_o stays 0 through and after reset; conflict_cnt_o=0.

Source files
------------

// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg -- shared definitions for the register-file writeback arbiter.
//   RF_RAW / RF_DW : default address / data widths
//   CNT_W          : width of the conflict counter
//   wb_req_t       : one writeback request {valid, addr, data} at default widths
//   gnt_e          : identifies which requester was granted
//   sat_inc        : saturating increment for the conflict counter
// ---------------------------------------------------------------------------
package rf_pkg;

    localparam int RF_RAW = 4;
    localparam int RF_DW  = 8;
    localparam int CNT_W  = 8;

    typedef struct packed {
        logic              valid;
        logic [RF_RAW-1:0] addr;
        logic [RF_DW-1:0]  data;
    } wb_req_t;

    typedef enum logic {
        GNT_ALU = 1'b0,
        GNT_LD  = 1'b1
    } gnt_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rf_wb_rr_pick.sv
// ---------------------------------------------------------------------------
// rf_wb_rr_pick -- two-way grant selection between ALU and load writeback.
//   clk, rst_n  : clock / async active-low reset (round-robin build only)
//   en_i        : grant enable (low while stalled or in reset)
//   alu_req_i   : ALU request valid
//   ld_req_i    : load request valid
//   alu_gnt_o   : ALU granted this cycle
//   ld_gnt_o    : load granted this cycle
// Configuration macro: RF_WB_RR_EN
//   defined   -> round-robin on conflict, pointer last_gnt_q
//   undefined -> fixed priority, load always beats ALU, no pointer state
// ---------------------------------------------------------------------------
module rf_wb_rr_pick
    import rf_pkg::*;
(
`ifdef RF_WB_RR_EN
    input  logic clk,
    input  logic rst_n,
`endif
    input  logic en_i,
    input  logic alu_req_i,
    input  logic ld_req_i,
    output logic alu_gnt_o,
    output logic ld_gnt_o
);

`ifdef RF_WB_RR_EN
    gnt_e last_gnt_q;
    gnt_e last_gnt_d;

    always_comb begin
        alu_gnt_o = 1'b0;
        ld_gnt_o  = 1'b0;
        if (en_i) begin
            if (alu_req_i && ld_req_i) begin
                // Conflict: whoever did not win last time goes now.
                alu_gnt_o = (last_gnt_q == GNT_LD);
                ld_gnt_o  = (last_gnt_q == GNT_ALU);
            end else begin
                alu_gnt_o = alu_req_i;
                ld_gnt_o  = ld_req_i;
            end
        end
    end

    // A grant is always a transfer (grant implies valid), so the pointer
    // tracks every grant, not only contested ones.
    always_comb begin
        last_gnt_d = last_gnt_q;
        if (alu_gnt_o) begin
            last_gnt_d = GNT_ALU;
        end else if (ld_gnt_o) begin
            last_gnt_d = GNT_LD;
        end
    end

    // Reset to "load won last" so the ALU takes the first conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_q <= GNT_LD;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end
`else
    always_comb begin
        ld_gnt_o  = en_i & ld_req_i;
        alu_gnt_o = en_i & alu_req_i & ~ld_req_i;
    end
`endif

endmodule

// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter -- merges ALU and load writebacks onto one register-file
// write port.
//   clk, rst_n                         : clock, async active-low reset
//   alu_valid_i/alu_addr_i/alu_data_i  : ALU writeback request
//   alu_ready_o                        : ALU request accepted this cycle
//   ld_valid_i/ld_addr_i/ld_data_i     : load writeback request
//   ld_ready_o                         : load request accepted this cycle
//   stall_i                            : blocks all grants
//   wen_o/write_addr_o/write_data_o    : registered register-file write
//   conflict_cnt_o                     : saturating count of contested cycles
// Configuration macro: RF_WB_RR_EN (round-robin when defined, otherwise
// load has fixed priority over ALU).
// Requesters are not buffered: an ungranted requester must hold its request.
// ---------------------------------------------------------------------------
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int RAW = RF_RAW,
    parameter int DW  = RF_DW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alu_valid_i,
    input  logic [RAW-1:0]   alu_addr_i,
    input  logic [DW-1:0]    alu_data_i,
    output logic             alu_ready_o,
    input  logic             ld_valid_i,
    input  logic [RAW-1:0]   ld_addr_i,
    input  logic [DW-1:0]    ld_data_i,
    output logic             ld_ready_o,
    input  logic             stall_i,
    output logic             wen_o,
    output logic [RAW-1:0]   write_addr_o,
    output logic [DW-1:0]    write_data_o,
    output logic [CNT_W-1:0] conflict_cnt_o
);

    // Same layout as rf_pkg::wb_req_t, but at this instance's widths.
    typedef struct packed {
        logic           valid;
        logic [RAW-1:0] addr;
        logic [DW-1:0]  data;
    } req_t;

    req_t alu_req;
    req_t ld_req;

    assign alu_req = {alu_valid_i, alu_addr_i, alu_data_i};
    assign ld_req  = {ld_valid_i, ld_addr_i, ld_data_i};

    logic grant_en;
    logic alu_gnt;
    logic ld_gnt;

    // Gating with rst_n keeps both readies low during reset even though the
    // grant path is purely combinational.
    assign grant_en = ~stall_i & rst_n;

    rf_wb_rr_pick u_pick (
`ifdef RF_WB_RR_EN
        .clk       (clk),
        .rst_n     (rst_n),
`endif
        .en_i      (grant_en),
        .alu_req_i (alu_req.valid),
        .ld_req_i  (ld_req.valid),
        .alu_gnt_o (alu_gnt),
        .ld_gnt_o  (ld_gnt)
    );

    assign alu_ready_o = alu_gnt;
    assign ld_ready_o  = ld_gnt;

    logic             wen_q,   wen_d;
    logic [RAW-1:0]   waddr_q, waddr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    // Address/data hold their last value when nothing is granted so the
    // register-file port does not toggle on idle cycles.
    always_comb begin
        wen_d   = alu_gnt | ld_gnt;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (ld_gnt) begin
            waddr_d = ld_req.addr;
            wdata_d = ld_req.data;
        end else if (alu_gnt) begin
            waddr_d = alu_req.addr;
            wdata_d = alu_req.data;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (alu_req.valid && ld_req.valid && !stall_i) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    // Reset also drops any write granted in the cycle it lands in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign wen_o          = wen_q;
    assign write_addr_o   = waddr_q;
    assign write_data_o   = wdata_q;
    assign conflict_cnt_o = cnt_q;

endmodule
